// File: rtl/ps2_text_pkg.sv
// Shared scan-code constants and FSM state encoding for the PS/2 text writer.
package ps2_text_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        S_MAKE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } ps2_state_t;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_text_writer_if.sv
// Scan-code input strobe and text-RAM write port of the PS/2 text writer.
interface ps2_text_writer_if #(
    parameter int ADDR_W = 13
);
    logic              code_valid;
    logic [7:0]        code;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_data;
    logic [ADDR_W-1:0] cursor_addr;

    modport master (
        output code_valid, code,
        input  mem_addr, mem_we, mem_data, cursor_addr
    );

    modport slave (
        input  code_valid, code,
        output mem_addr, mem_we, mem_data, cursor_addr
    );
endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational PS/2 set-2 scan code to ASCII lookup; returns 0x00 for unmapped codes.
module ps2_scan2ascii (
    input  logic [7:0] i_code,
    input  logic       i_shift,
    output logic [7:0] o_ascii
);

    always_comb begin
        o_ascii = 8'h00;
        case (i_code)
            8'h1C: o_ascii = 8'h61;
            8'h32: o_ascii = 8'h62;
            8'h21: o_ascii = 8'h63;
            8'h23: o_ascii = 8'h64;
            8'h24: o_ascii = 8'h65;
            8'h2B: o_ascii = 8'h66;
            8'h34: o_ascii = 8'h67;
            8'h33: o_ascii = 8'h68;
            8'h43: o_ascii = 8'h69;
            8'h3B: o_ascii = 8'h6A;
            8'h42: o_ascii = 8'h6B;
            8'h4B: o_ascii = 8'h6C;
            8'h3A: o_ascii = 8'h6D;
            8'h31: o_ascii = 8'h6E;
            8'h44: o_ascii = 8'h6F;
            8'h4D: o_ascii = 8'h70;
            8'h15: o_ascii = 8'h71;
            8'h2D: o_ascii = 8'h72;
            8'h1B: o_ascii = 8'h73;
            8'h2C: o_ascii = 8'h74;
            8'h3C: o_ascii = 8'h75;
            8'h2A: o_ascii = 8'h76;
            8'h1D: o_ascii = 8'h77;
            8'h22: o_ascii = 8'h78;
            8'h35: o_ascii = 8'h79;
            8'h1A: o_ascii = 8'h7A;
            8'h45: o_ascii = i_shift ? 8'h29 : 8'h30;
            8'h16: o_ascii = i_shift ? 8'h21 : 8'h31;
            8'h1E: o_ascii = i_shift ? 8'h40 : 8'h32;
            8'h26: o_ascii = i_shift ? 8'h23 : 8'h33;
            8'h25: o_ascii = i_shift ? 8'h24 : 8'h34;
            8'h2E: o_ascii = i_shift ? 8'h25 : 8'h35;
            8'h36: o_ascii = i_shift ? 8'h5E : 8'h36;
            8'h3D: o_ascii = i_shift ? 8'h26 : 8'h37;
            8'h3E: o_ascii = i_shift ? 8'h2A : 8'h38;
            8'h46: o_ascii = i_shift ? 8'h28 : 8'h39;
            8'h29: o_ascii = 8'h20;
            8'h41: o_ascii = 8'h2C;
            8'h49: o_ascii = 8'h2E;
            8'h4E: o_ascii = 8'h2D;
            8'h55: o_ascii = 8'h3D;
            default: o_ascii = 8'h00;
        endcase
        // Lower-case letters sit at 0x61..0x7A; clearing bit 5 gives upper case.
        if (i_shift && (o_ascii >= 8'h61) && (o_ascii <= 8'h7A)) begin
            o_ascii = o_ascii & 8'hDF;
        end
    end

endmodule

// File: rtl/ps2_text_writer.sv
// PS/2 scan codes to VGA text-RAM writes with cursor, backspace, enter and wrap-around.
// Optional shift-key support is enabled by defining PS2_TEXT_SHIFT_EN.
//
// state       | meaning
// S_MAKE      | idle; next code is a make code or a prefix
// S_BREAK     | F0 seen; next code is a released key
// S_EXT       | E0 seen; extended key, ignored
// S_EXT_BREAK | E0 F0 seen; extended key release, ignored
module ps2_text_writer
    import ps2_text_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 13
) (
    input  logic              CLK_50M,
    input  logic              RESET,
    ps2_text_writer_if.slave  bus
);

    localparam int                N        = COLS * ROWS;
    localparam int                COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N - COLS);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);

    ps2_state_t        r_state;
    ps2_state_t        w_state_next;
    logic [ADDR_W-1:0] r_row_start;
    logic [ADDR_W-1:0] w_row_next;
    logic [ADDR_W-1:0] w_row_inc;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  w_col_next;
    logic [ADDR_W-1:0] r_cursor;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_waddr;
    logic              r_mem_we;
    logic              w_we;
    logic [7:0]        r_mem_data;
    logic [7:0]        w_wdata;
    logic [7:0]        w_ascii;
    logic              w_shift;
    logic              w_is_shift;

`ifdef PS2_TEXT_SHIFT_EN
    logic r_shift;

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_shift <= 1'b0;
        end else if (bus.code_valid && w_is_shift) begin
            if (r_state == S_MAKE) begin
                r_shift <= 1'b1;
            end else if (r_state == S_BREAK) begin
                r_shift <= 1'b0;
            end
        end
    end

    assign w_shift    = r_shift;
    assign w_is_shift = is_shift_code(bus.code);
`else
    assign w_shift    = 1'b0;
    assign w_is_shift = 1'b0;
`endif

    ps2_scan2ascii u_scan2ascii (
        .i_code  (bus.code),
        .i_shift (w_shift),
        .o_ascii (w_ascii)
    );

    assign w_row_inc = (r_row_start == LAST_ROW) ? '0 : r_row_start + ROW_STEP;

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state     <= S_MAKE;
            r_row_start <= '0;
            r_col       <= '0;
            r_cursor    <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_data  <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_row_start <= w_row_next;
            r_col       <= w_col_next;
            r_cursor    <= w_row_next + ADDR_W'(w_col_next);
            r_mem_addr  <= w_waddr;
            r_mem_we    <= w_we;
            r_mem_data  <= w_wdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row_start;
        w_col_next   = r_col;
        w_we         = 1'b0;
        w_waddr      = r_mem_addr;
        w_wdata      = r_mem_data;
        if (bus.code_valid) begin
            case (r_state)
                S_MAKE: begin
                    if (bus.code == SC_BREAK) begin
                        w_state_next = S_BREAK;
                    end else if (bus.code == SC_EXT) begin
                        w_state_next = S_EXT;
                    end else if (bus.code == SC_BKSP) begin
                        w_we    = 1'b1;
                        w_wdata = ASCII_SPACE;
                        // Backspace at cell 0 blanks it but the cursor stays put.
                        if (r_cursor == '0) begin
                            w_waddr = '0;
                        end else if (r_col == '0) begin
                            w_col_next = COL_LAST;
                            w_row_next = r_row_start - ROW_STEP;
                            w_waddr    = r_cursor - ADDR_W'(1);
                        end else begin
                            w_col_next = r_col - COL_W'(1);
                            w_waddr    = r_cursor - ADDR_W'(1);
                        end
                    end else if (bus.code == SC_ENTER) begin
                        w_col_next = '0;
                        w_row_next = w_row_inc;
                    end else if (w_is_shift) begin
                        w_we = 1'b0;
                    end else if (w_ascii != 8'h00) begin
                        w_we    = 1'b1;
                        w_waddr = r_cursor;
                        w_wdata = w_ascii;
                        if (r_col == COL_LAST) begin
                            w_col_next = '0;
                            w_row_next = w_row_inc;
                        end else begin
                            w_col_next = r_col + COL_W'(1);
                        end
                    end
                end
                S_BREAK: w_state_next = S_MAKE;
                S_EXT: w_state_next = (bus.code == SC_BREAK) ? S_EXT_BREAK : S_MAKE;
                S_EXT_BREAK: w_state_next = S_MAKE;
                default: w_state_next = S_MAKE;
            endcase
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_data    = r_mem_data;
    assign bus.cursor_addr = r_cursor;

endmodule

// File: tb/tb_ps2_text_writer.sv
// Scoreboard bench for ps2_text_writer: directed corner cases plus random scan-code traffic.
// Honours PS2_TEXT_SHIFT_EN the same way as the design build.
module tb_ps2_text_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int N      = COLS * ROWS;
    localparam int ADDR_W = 13;
`ifdef PS2_TEXT_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic CLK_50M = 1'b0;
    logic RESET   = 1'b1;
    always #10 CLK_50M = ~CLK_50M;

    ps2_text_writer_if #(.ADDR_W(ADDR_W)) bus ();

    ps2_text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .CLK_50M (CLK_50M),
        .RESET   (RESET),
        .bus     (bus)
    );

    typedef struct {
        bit we;
        int addr;
        int data;
        int cur;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    pend = 1'b0;

    int    m_cur   = 0;
    bit    m_shift = 1'b0;
    int    m_pend  = 0;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0

    int    let_sc[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43, 'h3B, 'h42, 'h4B, 'h3A,
                          'h31, 'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
    int    dig_sc[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
    string lower_s = "abcdefghijklmnopqrstuvwxyz";
    string dsym_s  = ")!@#$%^&*(";
    int    pool[16] = '{'hF0, 'hE0, 'h66, 'h5A, 'h12, 'h59, 'h75, 'h76, 'h29, 'h41, 'h49, 'h4E, 'h55, 'h00, 'h1C, 'h45};

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int ref_ascii(input int sc, input bit sh);
        for (int i = 0; i < 26; i++) begin
            if (sc == let_sc[i]) return sh ? int'(lower_s[i]) - 32 : int'(lower_s[i]);
        end
        for (int i = 0; i < 10; i++) begin
            if (sc == dig_sc[i]) return sh ? int'(dsym_s[i]) : 48 + i;
        end
        case (sc)
            'h29: return 32;
            'h41: return 44;
            'h49: return 46;
            'h4E: return 45;
            'h55: return 61;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_shift(input int c);
        return SHIFT_EN && (c == 'h12 || c == 'h59);
    endfunction

    task automatic model_code(input int c);
        exp_t e;
        int   a;
        e.we = 1'b0; e.addr = 0; e.data = 0;
        case (m_pend)
            0: begin
                if (c == 'hF0) m_pend = 1;
                else if (c == 'hE0) m_pend = 2;
                else if (c == 'h66) begin
                    if (m_cur > 0) m_cur = m_cur - 1;
                    e.we = 1'b1; e.addr = m_cur; e.data = 32;
                end else if (c == 'h5A) begin
                    m_cur = ((m_cur / COLS + 1) % ROWS) * COLS;
                end else if (is_shift(c)) begin
                    m_shift = 1'b1;
                end else begin
                    a = ref_ascii(c, m_shift);
                    if (a != 0) begin
                        e.we = 1'b1; e.addr = m_cur; e.data = a;
                        m_cur = (m_cur + 1) % N;
                    end
                end
            end
            1: begin
                if (is_shift(c)) m_shift = 1'b0;
                m_pend = 0;
            end
            2: m_pend = (c == 'hF0) ? 3 : 0;
            default: m_pend = 0;
        endcase
        e.cur = m_cur;
        exp_q.push_back(e);
    endtask

    task automatic send(input int c);
        @(negedge CLK_50M);
        bus.code_valid = 1'b1;
        bus.code       = 8'(c);
        model_code(c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK_50M);
            bus.code_valid = 1'b0;
        end
    endtask

    task automatic type_n(input int n);
        for (int i = 0; i < n; i++) send(let_sc[$urandom_range(0, 25)]);
    endtask

    task automatic enter_n(input int n);
        for (int i = 0; i < n; i++) send('h5A);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
        check({tag, "_mem_we"}, int'(bus.mem_we), 0);
        check({tag, "_mem_data"}, int'(bus.mem_data), 0);
        check({tag, "_cursor"}, int'(bus.cursor_addr), 0);
    endtask

    task automatic do_reset();
        idle(1);
        @(negedge CLK_50M);
        RESET = 1'b1;
        repeat (2) @(negedge CLK_50M);
        RESET = 1'b0;
        m_cur = 0; m_shift = 1'b0; m_pend = 0;
    endtask

    always @(posedge CLK_50M) pend <= bus.code_valid && !RESET;

    always @(negedge CLK_50M) begin
        exp_t e;
        if (pend) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("mem_we", int'(bus.mem_we), int'(e.we));
                if (e.we) begin
                    check("mem_addr", int'(bus.mem_addr), e.addr);
                    check("mem_data", int'(bus.mem_data), e.data);
                end
                check("cursor_addr", int'(bus.cursor_addr), e.cur);
            end
        end else if (bus.mem_we) begin
            check("spurious_we", 1, 0);
        end
    end

    initial begin
        int c;
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        repeat (3) @(negedge CLK_50M);
        RESET = 1'b0;
        check_reset_values("reset");

        send('h1C); idle(1);
        send('hF0); send('h1C); idle(1);
        send('h32); idle(1);

        do_reset();
        type_n(5); send('h5A);
        enter_n(28); type_n(70); send('h5A); idle(1);

        enter_n(29); type_n(79); send('h1C); send('h66);
        send('h5A); send('h66); idle(1);

        send('hE0); send('h75); send('hE0); send('hF0); send('h75); send('h1C); idle(1);

        send('h12); send('h1C); send('hF0); send('h12); send('h1C);
        send('h59); send('h16); send('hF0); send('h59); send('h16); idle(1);

        send('hF0); do_reset();
        check_reset_values("reset_after_f0");
        send('h1C); idle(1);

        @(negedge CLK_50M);
        RESET = 1'b1;
        bus.code_valid = 1'b1;
        bus.code = 8'h1C;
        @(negedge CLK_50M);
        bus.code_valid = 1'b0;
        @(negedge CLK_50M);
        RESET = 1'b0;
        m_cur = 0; m_shift = 1'b0; m_pend = 0;
        check_reset_values("reset_vs_valid");

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = let_sc[$urandom_range(0, 25)];
                4, 5, 6:    c = pool[$urandom_range(0, 15)];
                7:          c = dig_sc[$urandom_range(0, 9)];
                default:    c = int'($urandom_range(0, 255));
            endcase
            send(c);
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("sb_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
